// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the 5-stage pipelined core.
//
// Purpose:
//   Sits directly behind the MEM/WB pipeline register. Selects and formats the
//   register-file write data, drives the register-file write port, keeps a
//   one-entry WB->ID bypass register, counts retired instructions and runs the
//   halt sequence (RUN -> DRAIN -> HALTED) that stops the core cleanly.
//
// Optional feature:
//   WB_BRSTAT_EN -- when defined, NUM_BR_TAKEN counts retired taken
//   control-flow instructions. When undefined, NUM_BR_TAKEN is tied to zero.
//
// Parameters:
//   DRAIN_CYCLES  cycles spent in DRAIN after a retiring HALT (0..15)
//   CNT_W         width of the statistics counters
//
// Ports:
//   CLK, RSTn       clock (posedge), asynchronous active-low reset
//   RWSrc           write-data select: 00 ALUOUT, 01 load, 10 ADD_PC, 11 zero
//   OPSrc           load format: 00 word, 01 sbyte, 10 shalf, 11 ubyte
//   PCSrc           nonzero = retiring instruction is control-flow
//   RF_WE           write enable from MEM/WB
//   NUM_CHECK       a real instruction (not a bubble) is retiring
//   ALUOUT          ALU result / memory address
//   ADD_PC          PC+4 of the retiring instruction
//   D_MEM_DI        raw data-memory read word
//   WA              destination register
//   HALT_IN         retiring instruction is HALT
//   Branch_Cond     branch condition evaluated true
//   RF_WA/RF_WD/RF_WE_OUT   register-file write port (combinational)
//   FWD_VALID/FWD_WA/FWD_WD bypass register (registered)
//   NUM_INST        retired-instruction count
//   NUM_BR_TAKEN    taken control-flow count (zero unless WB_BRSTAT_EN)
//   HALT_OUT        core halted (registered)
//   dbg_state       current halt FSM state (0 RUN, 1 DRAIN, 2 HALTED)
//
// Handshake note: this stage has no valid/ready flow control. NUM_CHECK acts
// as the per-cycle valid qualifier for counting and halting; RF_WE qualifies
// the write. The stage never stalls, so there is no ready.
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [1:0]       RWSrc,
  input  logic [1:0]       OPSrc,
  input  logic [1:0]       PCSrc,
  input  logic             RF_WE,
  input  logic             NUM_CHECK,
  input  logic [31:0]      ALUOUT,
  input  logic [31:0]      ADD_PC,
  input  logic [31:0]      D_MEM_DI,
  input  logic [4:0]       WA,
  input  logic             HALT_IN,
  input  logic             Branch_Cond,
  output logic [4:0]       RF_WA,
  output logic [31:0]      RF_WD,
  output logic             RF_WE_OUT,
  output logic             FWD_VALID,
  output logic [4:0]       FWD_WA,
  output logic [31:0]      FWD_WD,
  output logic [CNT_W-1:0] NUM_INST,
  output logic [CNT_W-1:0] NUM_BR_TAKEN,
  output logic             HALT_OUT,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Drain counter is 4 bits wide; DRAIN_CYCLES is legal only in 0..15.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic             halt_out_q, halt_out_d;

  logic             fwd_valid_q, fwd_valid_d;
  logic [4:0]       fwd_wa_q, fwd_wa_d;
  logic [31:0]      fwd_wd_q, fwd_wd_d;

  logic [CNT_W-1:0] num_inst_q, num_inst_d;

  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_data;
  logic [31:0]      wd;
  logic             rf_we_out;
  logic             not_halted;

  assign not_halted = (state_q != ST_HALTED);

  // ---------------------------------------------------------------------------
  // Load formatting. Byte lane chosen by ALUOUT[1:0], half lane by ALUOUT[1];
  // a misaligned half (ALUOUT[0]=1) simply ignores bit 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = 8'h00;
    case (ALUOUT[1:0])
      2'd0:    load_byte = D_MEM_DI[7:0];
      2'd1:    load_byte = D_MEM_DI[15:8];
      2'd2:    load_byte = D_MEM_DI[23:16];
      default: load_byte = D_MEM_DI[31:24];
    endcase

    load_half = ALUOUT[1] ? D_MEM_DI[31:16] : D_MEM_DI[15:0];

    load_data = D_MEM_DI;
    case (OPSrc)
      2'b00:   load_data = D_MEM_DI;
      2'b01:   load_data = {{24{load_byte[7]}}, load_byte};
      2'b10:   load_data = {{16{load_half[15]}}, load_half};
      default: load_data = {24'h000000, load_byte};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-data select (purely combinational, no added latency).
  // ---------------------------------------------------------------------------
  always_comb begin
    wd = 32'h0;
    case (RWSrc)
      2'b00:   wd = ALUOUT;
      2'b01:   wd = load_data;
      2'b10:   wd = ADD_PC;
      default: wd = 32'h0;
    endcase
  end

  // x0 is hardwired to zero, so its writes never reach the register file.
  // During reset state_q is RUN, so only the WA gate applies.
  assign rf_we_out = RF_WE & (WA != 5'd0) & not_halted;

  assign RF_WA     = WA;
  assign RF_WD     = wd;
  assign RF_WE_OUT = rf_we_out;

  // ---------------------------------------------------------------------------
  // Halt FSM next-state and registered HALT_OUT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halt_out_d  = halt_out_q;
    case (state_q)
      ST_RUN: begin
        // A flushed HALT (NUM_CHECK=0) never starts the sequence.
        if (HALT_IN && NUM_CHECK) begin
          if (DRAIN_INIT == 4'd0) begin
            state_d    = ST_HALTED;
            halt_out_d = 1'b1;
          end else begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end
      ST_DRAIN: begin
        // The <= also covers a zero count, so DRAIN can never stick.
        if (drain_cnt_q <= 4'd1) begin
          state_d     = ST_HALTED;
          drain_cnt_d = 4'd0;
          halt_out_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      ST_HALTED: begin
        halt_out_d = 1'b1;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 4'd0;
        halt_out_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
      halt_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halt_out_q  <= halt_out_d;
    end
  end

  assign HALT_OUT  = halt_out_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Bypass register: captures every committed write, valid for one cycle.
  // Address/data hold when no write commits.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_valid_d = rf_we_out;
    fwd_wa_d    = fwd_wa_q;
    fwd_wd_d    = fwd_wd_q;
    if (rf_we_out) begin
      fwd_wa_d = WA;
      fwd_wd_d = wd;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fwd_valid_q <= 1'b0;
      fwd_wa_q    <= 5'd0;
      fwd_wd_q    <= 32'h0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_wa_q    <= fwd_wa_d;
      fwd_wd_q    <= fwd_wd_d;
    end
  end

  assign FWD_VALID = fwd_valid_q;
  assign FWD_WA    = fwd_wa_q;
  assign FWD_WD    = fwd_wd_q;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter. Counts in RUN and DRAIN (the retiring HALT
  // itself is counted), freezes in HALTED, wraps naturally.
  // ---------------------------------------------------------------------------
  always_comb begin
    num_inst_d = num_inst_q;
    if (NUM_CHECK && not_halted) begin
      num_inst_d = num_inst_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      num_inst_q <= '0;
    end else begin
      num_inst_q <= num_inst_d;
    end
  end

  assign NUM_INST = num_inst_q;

  // ---------------------------------------------------------------------------
  // Taken control-flow statistics.
  // ---------------------------------------------------------------------------
`ifdef WB_BRSTAT_EN
  logic [CNT_W-1:0] num_br_q, num_br_d;

  always_comb begin
    num_br_d = num_br_q;
    if (NUM_CHECK && (PCSrc != 2'b00) && Branch_Cond && not_halted) begin
      num_br_d = num_br_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      num_br_q <= '0;
    end else begin
      num_br_q <= num_br_d;
    end
  end

  assign NUM_BR_TAKEN = num_br_q;
`else
  // Branch inputs are only meaningful to the statistics counter.
  logic unused_br;
  assign unused_br    = ^{PCSrc, Branch_Cond};
  assign NUM_BR_TAKEN = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- directed self-checking bench for wb_stage.
// A second instance (CNT_W=4, DRAIN_CYCLES=0) shares all inputs and is used for
// the counter wrap boundary and the zero-length drain.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  // ---------------------------------------------------------------- clock/reset
  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- signals
  logic [1:0]  RWSrc, OPSrc, PCSrc;
  logic        RF_WE, NUM_CHECK, HALT_IN, Branch_Cond;
  logic [31:0] ALUOUT, ADD_PC, D_MEM_DI;
  logic [4:0]  WA;

  logic [4:0]  RF_WA, FWD_WA;
  logic [31:0] RF_WD, FWD_WD, NUM_INST, NUM_BR_TAKEN;
  logic        RF_WE_OUT, FWD_VALID, HALT_OUT;
  logic [1:0]  dbg_state;

  logic [4:0]  w_RF_WA, w_FWD_WA;
  logic [31:0] w_RF_WD, w_FWD_WD;
  logic [3:0]  w_NUM_INST, w_NUM_BR_TAKEN;
  logic        w_RF_WE_OUT, w_FWD_VALID, w_HALT_OUT;
  logic [1:0]  w_dbg_state;

  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2;
`ifdef WB_BRSTAT_EN
  localparam logic [31:0] EXP_BR4 = 32'd4;
  localparam logic [31:0] EXP_BR1 = 32'd1;
`else
  localparam logic [31:0] EXP_BR4 = 32'd0;
  localparam logic [31:0] EXP_BR1 = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  wb_stage #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .RWSrc(RWSrc), .OPSrc(OPSrc), .PCSrc(PCSrc),
    .RF_WE(RF_WE), .NUM_CHECK(NUM_CHECK), .ALUOUT(ALUOUT), .ADD_PC(ADD_PC),
    .D_MEM_DI(D_MEM_DI), .WA(WA), .HALT_IN(HALT_IN), .Branch_Cond(Branch_Cond),
    .RF_WA(RF_WA), .RF_WD(RF_WD), .RF_WE_OUT(RF_WE_OUT), .FWD_VALID(FWD_VALID),
    .FWD_WA(FWD_WA), .FWD_WD(FWD_WD), .NUM_INST(NUM_INST),
    .NUM_BR_TAKEN(NUM_BR_TAKEN), .HALT_OUT(HALT_OUT), .dbg_state(dbg_state)
  );

  wb_stage #(.DRAIN_CYCLES(0), .CNT_W(4)) dut_w (
    .CLK(CLK), .RSTn(RSTn), .RWSrc(RWSrc), .OPSrc(OPSrc), .PCSrc(PCSrc),
    .RF_WE(RF_WE), .NUM_CHECK(NUM_CHECK), .ALUOUT(ALUOUT), .ADD_PC(ADD_PC),
    .D_MEM_DI(D_MEM_DI), .WA(WA), .HALT_IN(HALT_IN), .Branch_Cond(Branch_Cond),
    .RF_WA(w_RF_WA), .RF_WD(w_RF_WD), .RF_WE_OUT(w_RF_WE_OUT),
    .FWD_VALID(w_FWD_VALID), .FWD_WA(w_FWD_WA), .FWD_WD(w_FWD_WD),
    .NUM_INST(w_NUM_INST), .NUM_BR_TAKEN(w_NUM_BR_TAKEN),
    .HALT_OUT(w_HALT_OUT), .dbg_state(w_dbg_state)
  );

  // ---------------------------------------------------------------- vectors
  logic [1:0]  ld_op   [10] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01,
                                2'b10, 2'b10, 2'b11, 2'b01, 2'b11};
  logic [31:0] ld_addr [10] = '{32'h2, 32'h3, 32'h2, 32'h0, 32'h1,
                                32'h0, 32'h3, 32'h0, 32'h3, 32'h1};
  logic [31:0] ld_exp  [10] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                32'h80FF7F01, 32'h0000007F, 32'h00007F01,
                                32'hFFFF80FF, 32'h00000001, 32'hFFFFFF80,
                                32'h0000007F};

  logic [1:0]  br_pc   [7] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1};
  logic        br_cond [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        br_chk  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  // ---------------------------------------------------------------- driver tasks
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    RWSrc = 2'b00; OPSrc = 2'b00; PCSrc = 2'b00;
    RF_WE = 1'b0; NUM_CHECK = 1'b0; HALT_IN = 1'b0; Branch_Cond = 1'b0;
    ALUOUT = 32'h0; ADD_PC = 32'h0; D_MEM_DI = 32'h0; WA = 5'd0;
  endtask

  // Called 1 ns after a posedge; releases reset well before the next edge.
  task automatic pulse_reset;
    RSTn = 1'b0;
    #2;
    RSTn = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    clear_inputs();
    RSTn = 1'b0;
    WA = 5'd0; RF_WE = 1'b1;
    #2;
    checks++; if (RF_WE_OUT !== 1'b0) begin errors++; $display("FAIL rst_we_x0: got %b expected 0", RF_WE_OUT); end
    checks++; if (HALT_OUT !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b expected 0", HALT_OUT); end
    checks++; if (NUM_INST !== 32'd0) begin errors++; $display("FAIL rst_num_inst: got %h expected 0", NUM_INST); end
    checks++; if (NUM_BR_TAKEN !== 32'd0) begin errors++; $display("FAIL rst_num_br: got %h expected 0", NUM_BR_TAKEN); end
    checks++; if (FWD_VALID !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid: got %b expected 0", FWD_VALID); end
    checks++; if (FWD_WA !== 5'd0 || FWD_WD !== 32'h0) begin errors++; $display("FAIL rst_fwd_data: got %h/%h expected 0/0", FWD_WA, FWD_WD); end
    checks++; if (dbg_state !== S_RUN) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_RUN); end
    // While held in reset the write strobe is still driven, gated only by WA.
    WA = 5'd5;
    #1;
    checks++; if (RF_WE_OUT !== 1'b1) begin errors++; $display("FAIL rst_we_wa5: got %b expected 1", RF_WE_OUT); end
    step();
    checks++; if (FWD_VALID !== 1'b0) begin errors++; $display("FAIL rst_fwd_held: got %b expected 0", FWD_VALID); end
    clear_inputs();
    RSTn = 1'b1;
  endtask

  task automatic test_alu_write;
    RWSrc = 2'b00; ALUOUT = 32'h1234; WA = 5'd5; RF_WE = 1'b1;
    #1;
    checks++; if (RF_WD !== 32'h1234) begin errors++; $display("FAIL alu_wd: got %h expected 00001234", RF_WD); end
    checks++; if (RF_WE_OUT !== 1'b1) begin errors++; $display("FAIL alu_we: got %b expected 1", RF_WE_OUT); end
    checks++; if (RF_WA !== 5'd5) begin errors++; $display("FAIL alu_wa: got %0d expected 5", RF_WA); end
    step();
    checks++; if (FWD_VALID !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid: got %b expected 1", FWD_VALID); end
    checks++; if (FWD_WA !== 5'd5) begin errors++; $display("FAIL alu_fwd_wa: got %0d expected 5", FWD_WA); end
    checks++; if (FWD_WD !== 32'h1234) begin errors++; $display("FAIL alu_fwd_wd: got %h expected 00001234", FWD_WD); end
    RF_WE = 1'b0;
  endtask

  task automatic test_loads;
    RWSrc = 2'b01; RF_WE = 1'b0; D_MEM_DI = 32'h80FF7F01;
    for (int i = 0; i < 10; i++) begin
      OPSrc = ld_op[i]; ALUOUT = ld_addr[i];
      #1;
      checks++;
      if (RF_WD !== ld_exp[i]) begin
        errors++;
        $display("FAIL load_%0d (op=%b addr=%0d): got %h expected %h", i, ld_op[i], ld_addr[i], RF_WD, ld_exp[i]);
      end
    end
    RWSrc = 2'b11;
    #1;
    checks++; if (RF_WD !== 32'h0) begin errors++; $display("FAIL rwsrc_reserved: got %h expected 00000000", RF_WD); end
  endtask

  task automatic test_x0_and_pc;
    step();
    WA = 5'd0; RF_WE = 1'b1; RWSrc = 2'b10; ADD_PC = 32'h40;
    #1;
    checks++; if (RF_WE_OUT !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", RF_WE_OUT); end
    checks++; if (RF_WD !== 32'h40) begin errors++; $display("FAIL addpc_wd: got %h expected 00000040", RF_WD); end
    step();
    checks++; if (FWD_VALID !== 1'b0) begin errors++; $display("FAIL x0_fwd_valid: got %b expected 0", FWD_VALID); end
    checks++; if (FWD_WA !== 5'd5 || FWD_WD !== 32'h1234) begin errors++; $display("FAIL fwd_hold: got %0d/%h expected 5/00001234", FWD_WA, FWD_WD); end
    clear_inputs();
  endtask

  task automatic test_count;
    step();
    pulse_reset();
    // 13 cycles, bubbles at 2, 6 and 10 -> 10 retired.
    for (int i = 0; i < 13; i++) begin
      NUM_CHECK = !(i == 2 || i == 6 || i == 10);
      step();
    end
    checks++; if (NUM_INST !== 32'd10) begin errors++; $display("FAIL count_10: got %0d expected 10", NUM_INST); end
    checks++; if (w_NUM_INST !== 4'd10) begin errors++; $display("FAIL count_w_10: got %0d expected 10", w_NUM_INST); end
    NUM_CHECK = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (w_NUM_INST !== 4'hF) begin errors++; $display("FAIL count_w_ones: got %h expected f", w_NUM_INST); end
    step();
    checks++; if (w_NUM_INST !== 4'h0) begin errors++; $display("FAIL count_w_wrap: got %h expected 0", w_NUM_INST); end
    checks++; if (NUM_INST !== 32'd16) begin errors++; $display("FAIL count_16: got %0d expected 16", NUM_INST); end
    NUM_CHECK = 1'b0;
  endtask

  task automatic test_branch_stats;
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      PCSrc = br_pc[i]; Branch_Cond = br_cond[i]; NUM_CHECK = br_chk[i];
      step();
    end
    clear_inputs();
    checks++; if (NUM_BR_TAKEN !== EXP_BR4) begin errors++; $display("FAIL br_taken: got %0d expected %0d", NUM_BR_TAKEN, EXP_BR4); end
    checks++; if (w_NUM_BR_TAKEN !== EXP_BR4[3:0]) begin errors++; $display("FAIL br_taken_w: got %0d expected %0d", w_NUM_BR_TAKEN, EXP_BR4[3:0]); end
    checks++; if (NUM_INST !== 32'd6) begin errors++; $display("FAIL br_num_inst: got %0d expected 6", NUM_INST); end
  endtask

  task automatic test_halt;
    step();
    pulse_reset();
    HALT_IN = 1'b1; NUM_CHECK = 1'b0;
    step();
    checks++; if (HALT_OUT !== 1'b0 || dbg_state !== S_RUN) begin errors++; $display("FAIL flushed_halt: got halt=%b state=%0d expected 0/0", HALT_OUT, dbg_state); end
    checks++; if (w_HALT_OUT !== 1'b0) begin errors++; $display("FAIL flushed_halt_w: got %b expected 0", w_HALT_OUT); end
    // Retiring HALT that also writes.
    NUM_CHECK = 1'b1; RF_WE = 1'b1; WA = 5'd7; RWSrc = 2'b00; ALUOUT = 32'hAB;
    #1;
    checks++; if (RF_WE_OUT !== 1'b1) begin errors++; $display("FAIL halt_writes: got %b expected 1", RF_WE_OUT); end
    step(); // edge 1
    checks++; if (HALT_OUT !== 1'b0 || dbg_state !== S_DRAIN) begin errors++; $display("FAIL halt_e1: got halt=%b state=%0d expected 0/1", HALT_OUT, dbg_state); end
    checks++; if (w_HALT_OUT !== 1'b1 || w_dbg_state !== S_HALTED) begin errors++; $display("FAIL halt_w_e1: got halt=%b state=%0d expected 1/2", w_HALT_OUT, w_dbg_state); end
    checks++; if (NUM_INST !== 32'd1) begin errors++; $display("FAIL halt_counted: got %0d expected 1", NUM_INST); end
    checks++; if (FWD_VALID !== 1'b1 || FWD_WD !== 32'hAB) begin errors++; $display("FAIL halt_fwd: got %b/%h expected 1/000000ab", FWD_VALID, FWD_WD); end
    HALT_IN = 1'b0; ALUOUT = 32'hCD;
    #1;
    checks++; if (RF_WE_OUT !== 1'b1) begin errors++; $display("FAIL drain_we: got %b expected 1", RF_WE_OUT); end
    checks++; if (w_RF_WE_OUT !== 1'b0) begin errors++; $display("FAIL halted_w_we: got %b expected 0", w_RF_WE_OUT); end
    step(); // edge 2
    checks++; if (HALT_OUT !== 1'b0) begin errors++; $display("FAIL halt_e2: got %b expected 0", HALT_OUT); end
    checks++; if (NUM_INST !== 32'd2 || FWD_WD !== 32'hCD) begin errors++; $display("FAIL drain_count: got %0d/%h expected 2/000000cd", NUM_INST, FWD_WD); end
    checks++; if (w_NUM_INST !== 4'd1) begin errors++; $display("FAIL halted_w_frozen: got %0d expected 1", w_NUM_INST); end
    step(); // edge 3
    checks++; if (HALT_OUT !== 1'b1 || dbg_state !== S_HALTED) begin errors++; $display("FAIL halt_e3: got halt=%b state=%0d expected 1/2", HALT_OUT, dbg_state); end
    checks++; if (NUM_INST !== 32'd3) begin errors++; $display("FAIL halt_e3_count: got %0d expected 3", NUM_INST); end
    checks++; if (RF_WE_OUT !== 1'b0) begin errors++; $display("FAIL halted_we: got %b expected 0", RF_WE_OUT); end
    HALT_IN = 1'b1;
    step();
    step();
    checks++; if (NUM_INST !== 32'd3) begin errors++; $display("FAIL halted_frozen: got %0d expected 3", NUM_INST); end
    checks++; if (HALT_OUT !== 1'b1 || FWD_VALID !== 1'b0) begin errors++; $display("FAIL halted_sticky: got halt=%b fwd=%b expected 1/0", HALT_OUT, FWD_VALID); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_drain;
    step();
    pulse_reset();
    HALT_IN = 1'b1; NUM_CHECK = 1'b1; PCSrc = 2'b01; Branch_Cond = 1'b1;
    RF_WE = 1'b1; WA = 5'd3; ALUOUT = 32'h55;
    step();
    clear_inputs();
    checks++; if (dbg_state !== S_DRAIN || NUM_INST !== 32'd1) begin errors++; $display("FAIL mid_pre: got state=%0d cnt=%0d expected 1/1", dbg_state, NUM_INST); end
    checks++; if (NUM_BR_TAKEN !== EXP_BR1) begin errors++; $display("FAIL mid_pre_br: got %0d expected %0d", NUM_BR_TAKEN, EXP_BR1); end
    #2;
    RSTn = 1'b0;
    #1;
    checks++; if (dbg_state !== S_RUN || HALT_OUT !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got state=%0d halt=%b expected 0/0", dbg_state, HALT_OUT); end
    checks++; if (NUM_INST !== 32'd0 || NUM_BR_TAKEN !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0/0", NUM_INST, NUM_BR_TAKEN); end
    checks++; if (FWD_VALID !== 1'b0 || FWD_WA !== 5'd0 || FWD_WD !== 32'h0) begin errors++; $display("FAIL mid_rst_fwd: got %b/%0d/%h expected 0/0/0", FWD_VALID, FWD_WA, FWD_WD); end
    checks++; if (w_HALT_OUT !== 1'b0) begin errors++; $display("FAIL mid_rst_w_halt: got %b expected 0", w_HALT_OUT); end
    #1;
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (HALT_OUT !== 1'b0 || dbg_state !== S_RUN) begin errors++; $display("FAIL post_rst_run: got halt=%b state=%0d expected 0/0", HALT_OUT, dbg_state); end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    RSTn = 1'b0;
    clear_inputs();
    test_reset();
    test_alu_write();
    test_loads();
    test_x0_and_pc();
    test_count();
    test_branch_stats();
    test_halt();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (write-back) stage of the 5-stage pipelined core. It sits directly downstream of the MEM/WB pipeline register and consumes its outputs.
- Selects and formats register-file write data and drives the register-file write port.
- Holds a one-entry WB→ID bypass register, counts retired instructions, and runs the halt sequence that stops the core cleanly.

Parameters:
- DRAIN_CYCLES, 2, cycles spent in DRAIN after a retiring HALT before HALT_OUT asserts (legal range 0..15).
- CNT_W, 32, width of the retired-instruction and branch-statistics counters.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RSTn  in  1  asynchronous active-low reset.
- RWSrc  in  2  write-data select: 00 ALUOUT, 01 load data, 10 ADD_PC, 11 reserved.
- OPSrc  in  2  load format: 00 word, 01 signed byte, 10 signed half, 11 unsigned byte.
- PCSrc  in  2  PC-source of the retiring instruction; nonzero means control-flow.
- RF_WE  in  1  write enable from MEM/WB.
- NUM_CHECK  in  1  1 = a real instruction (not a bubble) is retiring.
- ALUOUT  in  32  ALU result / memory address.
- ADD_PC  in  32  PC+4 of the retiring instruction.
- D_MEM_DI  in  32  raw data-memory read word.
- WA  in  5  destination register.
- HALT_IN  in  1  retiring instruction is HALT.
- Branch_Cond  in  1  branch condition evaluated true.
- RF_WA  out  5  register-file write address.
- RF_WD  out  32  register-file write data.
- RF_WE_OUT  out  1  register-file write strobe.
- FWD_VALID  out  1  bypass register holds a valid write.
- FWD_WA  out  5  bypass register address.
- FWD_WD  out  32  bypass register data.
- NUM_INST  out  CNT_W  retired-instruction count.
- NUM_BR_TAKEN  out  CNT_W  taken control-flow count (optional feature).
- HALT_OUT  out  1  core halted.

Behaviour:
- Write-data mux is combinational; no added latency between MEM/WB outputs and the RF port.
  - RWSrc=00 → ALUOUT.
  - RWSrc=10 → ADD_PC.
  - RWSrc=11 → 32'h0.
  - RWSrc=01 → load data, formatted by OPSrc:
    - word: D_MEM_DI unchanged.
    - byte: lane ALUOUT[1:0], lane 0 = bits 7:0; sign-extended (01) or zero-extended (11).
    - half: lane ALUOUT[1], lane 0 = bits 15:0; sign-extended.
    - Misaligned half (ALUOUT[0]=1): use lane ALUOUT[1], ignore bit 0.
- RF_WA = WA; RF_WD = formatted data.
- RF_WE_OUT = RF_WE & (WA != 0) & (state != HALTED). Writes to x0 are always suppressed.
- Bypass register (posedge):
  - When RF_WE_OUT=1, load FWD_WA←WA, FWD_WD←RF_WD, FWD_VALID←1.
  - Otherwise FWD_VALID←0; FWD_WA and FWD_WD hold.
- NUM_INST increments by 1 on posedge when NUM_CHECK=1 and state ∈ {RUN, DRAIN}. It wraps from all-ones to 0.
- A retiring HALT counts as an instruction.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN: HALT_IN & NUM_CHECK → DRAIN, drain counter loaded with DRAIN_CYCLES. If DRAIN_CYCLES=0, go directly to HALTED.
  - DRAIN: counter decrements each cycle; at 1 → HALTED. Writes and counting continue (bubbles expected). HALT_IN is ignored.
  - HALTED: absorbing state; only reset leaves it. HALT_OUT=1 registered output, asserted the cycle the state becomes HALTED.
- HALT_IN with NUM_CHECK=0 (flushed HALT) is ignored.
- A HALT instruction with RF_WE=1 still writes in its retiring cycle.
- Reset (async, any time including mid-DRAIN):
  - state→RUN, drain counter→0, HALT_OUT→0.
  - NUM_INST→0, NUM_BR_TAKEN→0.
  - FWD_VALID→0, FWD_WA→0, FWD_WD→0.
  - Combinational outputs follow inputs, except RF_WE_OUT, which stays gated by WA≠0.

Optional Feature:
- Macro WB_BRSTAT_EN.
- Defined: NUM_BR_TAKEN increments on posedge when NUM_CHECK=1, PCSrc≠00, Branch_Cond=1, and state≠HALTED. It wraps like NUM_INST and resets to 0.
- Undefined: NUM_BR_TAKEN is tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset → RF_WE_OUT=0 for WA=0, HALT_OUT=0, NUM_INST=0, FWD_VALID=0. Then RWSrc=00, ALUOUT=32'h1234, WA=5, RF_WE=1 → RF_WD=32'h1234, RF_WE_OUT=1; next cycle FWD_VALID=1, FWD_WA=5, FWD_WD=32'h1234.
- Loads, D_MEM_DI=32'h80FF7F01:
  - OPSrc=01, ALUOUT[1:0]=2 → RF_WD=32'hFFFFFFFF.
  - OPSrc=11, ALUOUT[1:0]=3 → 32'h00000080.
  - OPSrc=10, ALUOUT[1]=1 → 32'hFFFF80FF.
  - OPSrc=00 → 32'h80FF7F01.
- WA=0, RF_WE=1 → RF_WE_OUT=0, FWD_VALID=0 next cycle. RWSrc=10, ADD_PC=32'h40 → RF_WD=32'h40.
- 10 cycles with NUM_CHECK=1 interleaved with 3 bubbles → NUM_INST=10. Preload NUM_INST near wrap: 32'hFFFFFFFF +1 → 0.
- HALT_IN=1, NUM_CHECK=1 with DRAIN_CYCLES=2 → HALT_OUT rises exactly 3 posedges later. Afterwards RF_WE=1 yields RF_WE_OUT=0 and NUM_INST frozen. HALT_IN=1 with NUM_CHECK=0 → no halt.
- Assert RSTn=0 mid-DRAIN → immediate return to RUN, HALT_OUT=0, counters 0. With WB_BRSTAT_EN: 4 taken branches (PCSrc=01, Branch_Cond=1) plus 2 not-taken → NUM_BR_TAKEN=4.
